gw_flux_decoder: RTL and testbench



---
 rtl/gw_flux_pkg.sv | 36 +++
 rtl/gw_byte_unpacker.sv | 61 ++++++
 rtl/gw_flux_decoder.sv | 195 +++++++++++++++++++
 tb/tb_gw_flux_decoder.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gw_flux_pkg.sv
// Shared constants and types for the Greaseweazle write-flux stream decoder.
package gw_flux_pkg;

   localparam logic [7:0] FLUXOP_INDEX   = 8'h01;
   localparam logic [7:0] FLUXOP_SPACE   = 8'h02;
   localparam logic [7:0] FLUXOP_ASTABLE = 8'h03;
   localparam logic [7:0] DIRECT_MAX     = 8'd249;
   localparam logic [7:0] EXT_BASE       = 8'd250;
   localparam logic [7:0] OPC_PREFIX     = 8'hFF;
   localparam logic [7:0] TERMINATOR     = 8'h00;
   localparam int         N28_W          = 28;

   typedef enum logic [1:0] {
      ERR_NONE       = 2'd0,
      ERR_BAD_OPCODE = 2'd1,
      ERR_BAD_N28    = 2'd2,
      ERR_ABORT      = 2'd3
   } err_code_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_BYTE = 3'd1,
      ST_EXT  = 3'd2,
      ST_OPC  = 3'd3,
      ST_N28  = 3'd4,
      ST_EMIT = 3'd5,
      ST_DONE = 3'd6,
      ST_ERR  = 3'd7
   } state_e;

   // Two-byte form: hi = first byte - 250 (0..4), lo = second byte. Range 249..1524.
   function automatic logic [10:0] ext_value(input logic [2:0] hi, input logic [7:0] lo);
      return 11'(EXT_BASE) - 11'd1 + 11'(hi) * 11'd255 + 11'(lo);
   endfunction

endpackage

// File: rtl/gw_byte_unpacker.sv
// Splits 32-bit host words into a byte stream, byte 0 = [7:0] first.
module gw_byte_unpacker
   import gw_flux_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        flush,
   input  logic [31:0] s_data,
   input  logic        s_valid,
   output logic        s_ready,
   output logic [7:0]  b_data,
   output logic        b_valid,
   input  logic        b_ready
);

   logic [31:0] word_q, word_d;
   logic [1:0]  ptr_q, ptr_d;
   logic        full_q, full_d;
   logic        take_byte, last_byte, take_word;

   always_comb begin
      b_valid   = full_q;
      b_data    = word_q[{ptr_q, 3'b000} +: 8];
      take_byte = full_q && b_ready;
      last_byte = take_byte && (ptr_q == 2'd3);
      // A new word may land in the same cycle the last byte leaves.
      s_ready   = enable && !flush && (!full_q || last_byte);
      take_word = s_ready && s_valid;

      word_d = word_q;
      ptr_d  = ptr_q;
      full_d = full_q;
      if (take_byte) begin
         ptr_d = ptr_q + 2'd1;
         if (last_byte) full_d = 1'b0;
      end
      if (take_word) begin
         word_d = s_data;
         ptr_d  = 2'd0;
         full_d = 1'b1;
      end
      if (flush) begin
         ptr_d  = 2'd0;
         full_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         word_q <= '0;
         ptr_q  <= '0;
         full_q <= 1'b0;
      end else begin
         word_q <= word_d;
         ptr_q  <= ptr_d;
         full_q <= full_d;
      end
   end

endmodule

// File: rtl/gw_flux_decoder.sv
// Decodes the CMD_WRITE_FLUX byte stream into flux intervals (sample ticks).
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
module gw_flux_decoder
   import gw_flux_pkg::*;
#(
   parameter int INTERVAL_W = 28,
   parameter int CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic [31:0]           s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic [INTERVAL_W-1:0] flux_interval,
   output logic                  flux_valid,
   input  logic                  flux_ready,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [1:0]            err_code,
   output logic [CNT_W-1:0]      byte_count,
   output logic [CNT_W-1:0]      interval_count,
   output logic [2:0]            dbg_state
);

   state_e                state_q, state_d;
   err_code_e             err_code_q, err_code_d;
   logic [INTERVAL_W-1:0] flux_q, flux_d, space_q, space_d;
   logic [N28_W-1:0]      n28_q, n28_d, n28_next;
   logic [1:0]            n28_idx_q, n28_idx_d;
   logic [4:0]            n28_sh;
   logic [2:0]            ext_hi_q, ext_hi_d;
   logic                  opc_space_q, opc_space_d;
   logic                  done_q, done_d, error_q, error_d;
   logic [CNT_W-1:0]      byte_cnt_q, byte_cnt_d, int_cnt_q, int_cnt_d;
   logic [7:0]            b_data;
   logic                  b_valid, b_ready, consume, flush, busy_st, byte_st;

   function automatic logic [INTERVAL_W-1:0] sat_add(input logic [INTERVAL_W-1:0] a,
                                                     input logic [INTERVAL_W-1:0] b);
      logic [INTERVAL_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[INTERVAL_W] ? '1 : s[INTERVAL_W-1:0];
   endfunction

   gw_byte_unpacker u_unpacker (
      .clk     (clk),
      .rst_n   (rst_n),
      .enable  (busy_st && !abort),
      .flush   (flush),
      .s_data  (s_data),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .b_data  (b_data),
      .b_valid (b_valid),
      .b_ready (b_ready)
   );

   always_comb begin
      busy_st  = state_q inside {ST_BYTE, ST_EXT, ST_OPC, ST_N28, ST_EMIT};
      byte_st  = state_q inside {ST_BYTE, ST_EXT, ST_OPC, ST_N28};
      b_ready  = byte_st && !start && !abort;
      consume  = b_valid && b_ready;
      n28_sh   = 5'(n28_idx_q) * 5'd7;
      n28_next = n28_q | (N28_W'(b_data[7:1]) << n28_sh);

      state_d     = state_q;
      err_code_d  = err_code_q;
      flux_d      = flux_q;
      space_d     = space_q;
      n28_d       = n28_q;
      n28_idx_d   = n28_idx_q;
      ext_hi_d    = ext_hi_q;
      opc_space_d = opc_space_q;
      done_d      = 1'b0;
      error_d     = error_q;
      byte_cnt_d  = byte_cnt_q;
      int_cnt_d   = int_cnt_q;
      flush       = start;

      if (start) begin
         state_d    = ST_BYTE;
         err_code_d = ERR_NONE;
         error_d    = 1'b0;
         space_d    = '0;
         byte_cnt_d = '0;
         int_cnt_d  = '0;
      end else if (abort && busy_st) begin
         state_d    = ST_ERR;
         err_code_d = ERR_ABORT;
         error_d    = 1'b1;
      end else begin
         if (consume) byte_cnt_d = byte_cnt_q + CNT_W'(1);
         case (state_q)
            ST_BYTE: if (consume) begin
               if (b_data == TERMINATOR) begin
                  // Any space not yet attached to an interval dies with the stream.
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  space_d = '0;
                  flush   = 1'b1;
               end else if (b_data <= DIRECT_MAX) begin
                  flux_d  = sat_add(space_q, INTERVAL_W'(b_data));
                  space_d = '0;
                  state_d = ST_EMIT;
               end else if (b_data == OPC_PREFIX) begin
                  state_d = ST_OPC;
               end else begin
                  ext_hi_d = 3'(b_data - EXT_BASE);
                  state_d  = ST_EXT;
               end
            end
            ST_EXT: if (consume) begin
               flux_d  = sat_add(space_q, INTERVAL_W'(ext_value(ext_hi_q, b_data)));
               space_d = '0;
               state_d = ST_EMIT;
            end
            ST_OPC: if (consume) begin
               if (b_data == FLUXOP_INDEX || b_data == FLUXOP_SPACE) begin
                  opc_space_d = (b_data == FLUXOP_SPACE);
                  n28_d       = '0;
                  n28_idx_d   = 2'd0;
                  state_d     = ST_N28;
               end else begin
                  state_d    = ST_ERR;
                  err_code_d = ERR_BAD_OPCODE;
                  error_d    = 1'b1;
               end
            end
            ST_N28: if (consume) begin
               if (!b_data[0]) begin
                  state_d    = ST_ERR;
                  err_code_d = ERR_BAD_N28;
                  error_d    = 1'b1;
               end else if (n28_idx_q == 2'd3) begin
                  if (opc_space_q) space_d = sat_add(space_q, INTERVAL_W'(n28_next));
                  state_d = ST_BYTE;
               end else begin
                  n28_d     = n28_next;
                  n28_idx_d = n28_idx_q + 2'd1;
               end
            end
            ST_EMIT: if (flux_ready) begin
               int_cnt_d = int_cnt_q + CNT_W'(1);
               state_d   = ST_BYTE;
            end
            default: ;
         endcase
      end

      // A pending interval is withdrawn the moment start or abort arrives.
      flux_valid     = (state_q == ST_EMIT) && !start && !abort;
      flux_interval  = flux_q;
      busy           = busy_st;
      done           = done_q;
      error          = error_q;
      err_code       = err_code_q;
      byte_count     = byte_cnt_q;
      interval_count = int_cnt_q;
      dbg_state      = state_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         err_code_q  <= ERR_NONE;
         flux_q      <= '0;
         space_q     <= '0;
         n28_q       <= '0;
         n28_idx_q   <= '0;
         ext_hi_q    <= '0;
         opc_space_q <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         byte_cnt_q  <= '0;
         int_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         err_code_q  <= err_code_d;
         flux_q      <= flux_d;
         space_q     <= space_d;
         n28_q       <= n28_d;
         n28_idx_q   <= n28_idx_d;
         ext_hi_q    <= ext_hi_d;
         opc_space_q <= opc_space_d;
         done_q      <= done_d;
         error_q     <= error_d;
         byte_cnt_q  <= byte_cnt_d;
         int_cnt_q   <= int_cnt_d;
      end
   end

endmodule

// File: tb/tb_gw_flux_decoder.sv
// Directed bench for gw_flux_decoder: hand-computed intervals, counters and error codes.
module tb_gw_flux_decoder;

   localparam int IW = 28;
   localparam int CW = 32;
   localparam int W_DONE = 0, W_ERR = 1, W_FV = 2, W_BYTES = 3;

   logic          clk = 1'b0;
   logic          rst_n, start, abort, s_valid, flux_ready;
   logic [31:0]   s_data;
   logic          s_ready, flux_valid, busy, done, error;
   logic [IW-1:0] flux_interval;
   logic [1:0]    err_code;
   logic [CW-1:0] byte_count, interval_count;
   logic [2:0]    dbg_state;

   int checks = 0;
   int errors = 0;
   logic [IW-1:0] exp_q[$];
   logic [IW-1:0] got_q[$];

   always #5 clk = ~clk;

   gw_flux_decoder #(.INTERVAL_W(IW), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .flux_interval(flux_interval), .flux_valid(flux_valid), .flux_ready(flux_ready),
      .busy(busy), .done(done), .error(error), .err_code(err_code),
      .byte_count(byte_count), .interval_count(interval_count), .dbg_state(dbg_state)
   );

   // Record every interval that will be handshaken on the coming edge.
   always @(negedge clk)
      if (rst_n && flux_valid && flux_ready) got_q.push_back(flux_interval);

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input string tag);
      int   n;
      logic ok;
      n = 0;
      ok = 1'b0;
      s_data = w;
      s_valid = 1'b1;
      while (!ok && n < 200) begin
         @(negedge clk);
         if (s_ready) ok = 1'b1;
         tick();
         n++;
      end
      s_valid = 1'b0;
      chk({tag, "_accept"}, ok, 1);
   endtask

   task automatic wait_for(input int what, input logic [31:0] arg, input string tag);
      int   n;
      logic seen;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 400) begin
         @(negedge clk);
         case (what)
            W_DONE:  seen = done;
            W_ERR:   seen = error;
            W_FV:    seen = flux_valid;
            W_BYTES: seen = (byte_count == arg);
            default: seen = 1'b1;
         endcase
         tick();
         n++;
      end
      chk({tag, "_wait"}, seen, 1);
   endtask

   task automatic check_flux(input string tag);
      logic [IW-1:0] g;
      chk({tag, "_n_intervals"}, got_q.size(), exp_q.size());
      foreach (exp_q[i]) begin
         g = ~exp_q[i];
         if (i < got_q.size()) g = got_q[i];
         chk($sformatf("%s_interval%0d", tag, i), g, exp_q[i]);
      end
      exp_q.delete();
      got_q.delete();
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0;
      s_valid = 1'b0; s_data = '0; flux_ready = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      chk("reset_ctrl", {s_ready, flux_valid, busy, done, error, err_code}, 0);
      chk("reset_flux", flux_interval, 0);
      chk("reset_counts", {byte_count, interval_count}, 0);
      tick();
      rst_n = 1'b1;
      tick();

      // abort while idle is ignored
      abort = 1'b1; tick(); abort = 1'b0;
      @(negedge clk);
      chk("idle_abort_err", {error, err_code}, 0);
      tick();

      // 1: direct bytes 01 32 F9 then terminator
      pulse_start();
      send_word(32'h00F93201, "t1");
      wait_for(W_DONE, 0, "t1_done");
      @(negedge clk);
      chk("t1_done_pulse_len", done, 0);
      chk("t1_busy", busy, 0);
      chk("t1_bytes", byte_count, 4);
      chk("t1_icount", interval_count, 3);
      exp_q.push_back(1); exp_q.push_back(50); exp_q.push_back(249);
      check_flux("t1");
      tick();

      // 2: two-byte forms at both ends of the range
      pulse_start();
      send_word(32'hFFFE01FA, "t2a");
      send_word(32'h00000000, "t2b");
      wait_for(W_DONE, 0, "t2_done");
      chk("t2_bytes", byte_count, 5);
      chk("t2_icount", interval_count, 2);
      exp_q.push_back(250); exp_q.push_back(1524);
      check_flux("t2");

      // 3: SPACE 1000 then 16
      pulse_start();
      send_word(32'h0FD102FF, "t3a");
      send_word(32'h00100101, "t3b");
      wait_for(W_DONE, 0, "t3_done");
      chk("t3_bytes", byte_count, 8);
      exp_q.push_back(1016);
      check_flux("t3");

      // INDEX value is discarded
      pulse_start();
      send_word(32'h050301FF, "idx_a");
      send_word(32'h000A0907, "idx_b");
      wait_for(W_DONE, 0, "idx_done");
      exp_q.push_back(10);
      check_flux("idx");

      // two maximal SPACEs then 1: saturates at 2^28-1
      pulse_start();
      send_word(32'hFFFF02FF, "sat_a");
      send_word(32'h02FFFFFF, "sat_b");
      send_word(32'hFFFFFFFF, "sat_c");
      send_word(32'h00000001, "sat_d");
      wait_for(W_DONE, 0, "sat_done");
      chk("sat_bytes", byte_count, 14);
      exp_q.push_back(28'hFFFFFFF);
      check_flux("sat");

      // SPACE followed directly by terminator emits nothing
      pulse_start();
      send_word(32'h0FD102FF, "sp0_a");
      send_word(32'h00000101, "sp0_b");
      wait_for(W_DONE, 0, "sp0_done");
      chk("sp0_icount", interval_count, 0);
      check_flux("sp0");

      // 4: bad opcode, then malformed N28
      pulse_start();
      send_word(32'h000005FF, "t4a");
      wait_for(W_ERR, 0, "t4a_err");
      @(negedge clk);
      chk("t4a_code", err_code, 1);
      chk("t4a_sready", s_ready, 0);
      chk("t4a_busy", busy, 0);
      chk("t4a_bytes", byte_count, 2);
      check_flux("t4a");
      tick();
      pulse_start();
      @(negedge clk);
      chk("t4_restart_clears", {error, err_code}, 0);
      tick();
      send_word(32'h00D001FF, "t4b");
      wait_for(W_ERR, 0, "t4b_err");
      chk("t4b_code", err_code, 2);
      chk("t4b_bytes", byte_count, 3);

      // 5: backpressure holds interval 5 for 50 cycles
      flux_ready = 1'b0;
      pulse_start();
      send_word(32'h00000605, "t5");
      wait_for(W_FV, 0, "t5_fv");
      begin
         logic stable;
         stable = 1'b1;
         repeat (50) begin
            @(negedge clk);
            if (!(flux_valid && flux_interval == 5 && !s_ready && byte_count == 1)) stable = 1'b0;
            tick();
         end
         chk("t5_hold_stable", stable, 1);
      end
      flux_ready = 1'b1;
      wait_for(W_DONE, 0, "t5_done");
      chk("t5_bytes", byte_count, 3);
      exp_q.push_back(5); exp_q.push_back(6);
      check_flux("t5");

      // 6: abort mid-N28
      pulse_start();
      send_word(32'h0FD102FF, "t6");
      wait_for(W_BYTES, 4, "t6_bytes");
      abort = 1'b1; tick(); abort = 1'b0;
      @(negedge clk);
      chk("t6_code", err_code, 3);
      chk("t6_error", error, 1);
      chk("t6_fv", flux_valid, 0);
      chk("t6_busy", busy, 0);
      tick();

      // abort while an interval is pending withdraws it in the same cycle
      flux_ready = 1'b0;
      pulse_start();
      send_word(32'h00000009, "ab_emit");
      wait_for(W_FV, 0, "ab_emit_fv");
      abort = 1'b1;
      @(negedge clk);
      chk("ab_emit_fv_drop", flux_valid, 0);
      tick();
      abort = 1'b0;
      flux_ready = 1'b1;
      @(negedge clk);
      chk("ab_emit_code", err_code, 3);
      chk("ab_emit_icount", interval_count, 0);
      tick();
      got_q.delete();

      // start and abort together: start wins
      start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
      @(negedge clk);
      chk("start_abort_busy", busy, 1);
      chk("start_abort_err", {error, err_code}, 0);
      tick();

      // reset mid-stream, then a fresh stream
      send_word(32'h0000F932, "rst_mid");
      wait_for(W_BYTES, 1, "rst_mid_bytes");
      rst_n = 1'b0;
      tick();
      @(negedge clk);
      chk("rst_mid_ctrl", {s_ready, flux_valid, busy, done, error, err_code}, 0);
      chk("rst_mid_flux", flux_interval, 0);
      chk("rst_mid_counts", {byte_count, interval_count}, 0);
      tick();
      rst_n = 1'b1;
      got_q.delete();
      tick();
      pulse_start();
      send_word(32'h00000007, "t6c");
      wait_for(W_DONE, 0, "t6c_done");
      chk("t6c_bytes", byte_count, 2);
      chk("t6c_icount", interval_count, 1);
      exp_q.push_back(7);
      check_flux("t6c");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
